rram_read_capture_fifo: RTL and testbench
=========================================

// Module: rram_read_capture_fifo
// PURPOSE
//   Downstream of the RRAM FSM: buffers read results (address + sense-amp data word) that the FSM
//   emits after each completed read/verify step, so the slower host readout path can drain them.
//   Show-ahead (first-word-fall-through) FIFO with occupancy, full/empty and a sticky overflow flag.
//   Sits between the FSM read_data_bits/rram_addr outputs and the host register/readout interface.
// PARAMETERS
//   DATA_W   48   width of one captured read word (matches FSM read_data_bits)
//   ADDR_W   16   width of captured RRAM address
//   DEPTH    8    number of entries; power of two, >= 2
//   CNT_W    $clog2(DEPTH)+1   occupancy counter width (derived, not overridden)
// PORTS
//   mclk        in   1        system clock; all logic on rising edge
//   rst         in   1        synchronous active-high reset
//   cap_valid   in   1        one-cycle strobe from FSM: a read result is present this cycle
//   cap_addr    in   ADDR_W   RRAM address of the result
//   cap_data    in   DATA_W   read data word of the result
//   clr         in   1        synchronous flush from host
//   pop         in   1        host consumes head entry this cycle
//   rd_valid    out  1        head entry valid (== !empty)
//   rd_addr     out  ADDR_W   head entry address
//   rd_data     out  DATA_W   head entry data
//   count       out  CNT_W    current occupancy 0..DEPTH
//   full        out  1        count == DEPTH
//   overflow    out  1        sticky: a cap_valid was dropped because FIFO was full
//   drop_cnt    out  16       dropped-entry count (only with READ_FIFO_DROP_CNT_EN)
// BEHAVIOUR
//   - Storage: DEPTH x (ADDR_W+DATA_W) register array; wr_ptr/rd_ptr of $clog2(DEPTH) bits,
//     wrap modulo DEPTH naturally; count register tracks occupancy (no ptr-compare ambiguity).
//   - Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, overflow=0, drop_cnt=0; rd_valid=0,
//     full=0; rd_addr/rd_data driven from array[0] (don't-care while rd_valid=0). Array not cleared.
//   - clr: same effect as reset on pointers/count/overflow/drop_cnt; overrides push and pop that cycle.
//   - Push accepted when cap_valid && (!full || pop_eff); entry written at wr_ptr, wr_ptr++.
//   - pop_eff = pop && rd_valid; pop while empty is ignored (no ptr move, no error).
//   - Push while full without pop: entry dropped, overflow<=1 (sticky until rst/clr).
//   - Full + push + pop same cycle: both happen, count stays DEPTH, no overflow.
//   - Empty + push + pop same cycle: pop ignored, push accepted, count 0->1.
//   - Latency: push at edge N -> rd_valid=1 and head data visible after edge N (cycle N+1).
//     pop at edge N -> next entry on rd_addr/rd_data after edge N, combinational from array[rd_ptr].
//   - count: +1 on push only, -1 on pop_eff only, unchanged on both/neither. full = (count==DEPTH).
//   - Wrap: after DEPTH pushes and pops pointers return to 0; order strictly preserved across wrap.
//   - Inputs cap_addr/cap_data sampled only on cycles with cap_valid=1.
// CONFIGURATION
//   READ_FIFO_DROP_CNT_EN defined: drop_cnt increments on each dropped push, saturates at 16'hFFFF,
//     cleared by rst/clr.
//   Not defined: drop_cnt port still present, tied to 16'h0; overflow behaviour unchanged.
// TESTING
//   1 rst 2 cycles -> count=0, rd_valid=0, full=0, overflow=0, drop_cnt=0.
//   2 push (0x0010,D0),(0x0011,D1),(0x0012,D2), then pop x3 -> rd_addr 0x0010,0x0011,0x0012 in order;
//     rd_valid=1 one cycle after first push; empty after third pop.
//   3 push 8 entries (DEPTH=8) -> full=1,count=8; 9th push -> dropped, overflow=1, drop_cnt=1 (EN);
//     head still entry 0.
//   4 full FIFO, push+pop same cycle -> count stays 8, overflow stays 0, new entry appears 8th.
//   5 empty, push+pop same cycle -> count=1, head = pushed entry; pop on empty alone -> no change.
//   6 3 entries + overflow set, assert clr with cap_valid=1 -> count=0, overflow=0, entry discarded;
//     then 20 push/pop pairs across wrap -> data order preserved, count never exceeds 1.

Source files
------------

// File: rtl/rram_read_capture_fifo_if.sv
// Capture/readout bundle between the RRAM FSM result stream, the host drain path and the
// read-capture FIFO. The master side drives captures and host controls; the slave is the FIFO.
interface rram_read_capture_fifo_if #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              cap_valid;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              clr;
    logic              pop;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;
    logic [15:0]       drop_cnt;

    modport master (
        output cap_valid, cap_addr, cap_data, clr, pop,
        input  rd_valid, rd_addr, rd_data, count, full, overflow, drop_cnt
    );

    modport slave (
        input  cap_valid, cap_addr, cap_data, clr, pop,
        output rd_valid, rd_addr, rd_data, count, full, overflow, drop_cnt
    );
endinterface

// File: rtl/rram_read_capture_fifo.sv
// Show-ahead FIFO buffering RRAM read results (address + data) for the host readout path.
// Optional saturating dropped-entry counter enabled by defining READ_FIFO_DROP_CNT_EN.
module rram_read_capture_fifo #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input logic                     mclk,
    input logic                     rst,
    rram_read_capture_fifo_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, rd_valid, pop_eff, push, drop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign rd_valid = (count_q != '0);
    assign pop_eff  = bus.pop && rd_valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign push     = bus.cap_valid && (!full || pop_eff) && !bus.clr;
    assign drop     = bus.cap_valid && full && !pop_eff && !bus.clr;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop_eff})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally left uncleared by reset; rd_valid qualifies the head.
    always_ff @(posedge mclk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {bus.cap_addr, bus.cap_data};
        end
    end

    assign bus.rd_valid = rd_valid;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.overflow = overflow_q;
    assign {bus.rd_addr, bus.rd_data} = mem_q[rd_ptr_q];

`ifdef READ_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clr) begin
            drop_cnt_d = 16'h0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'h1;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            drop_cnt_q <= 16'h0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_rram_read_capture_fifo.sv
// Bench for rram_read_capture_fifo: directed table, corner-case sequences and a random run
// checked against a queue-based reference model.
module tb_rram_read_capture_fifo;
    localparam int unsigned DATA_W = 48;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 8;
`ifdef READ_FIFO_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef logic [ADDR_W+DATA_W-1:0] entry_t;

    typedef struct {
        bit          v;
        logic [15:0] a;
        bit          c;
        bit          p;
        int          cnt;
        bit          rv;
        logic [15:0] ra;
        bit          fl;
        bit          ov;
        int          dr;
    } vec_t;

    logic mclk = 1'b0;
    logic rst  = 1'b1;
    always #5 mclk = ~mclk;

    rram_read_capture_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    rram_read_capture_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    int     passed = 0;
    int     total  = 0;
    entry_t model_q[$];
    bit     model_ovf;
    int     model_drops;
    vec_t   vecs[$];

    function automatic logic [DATA_W-1:0] mkdata(input logic [ADDR_W-1:0] a);
        return {a ^ 16'h5A5A, 16'hD00D, ~a};
    endfunction

    function automatic vec_t mk(input bit v, input logic [15:0] a, input bit c, input bit p,
                                input int cnt, input bit rv, input logic [15:0] ra,
                                input bit fl, input bit ov, input int dr);
        vec_t r;
        r.v = v; r.a = a; r.c = c; r.p = p; r.cnt = cnt; r.rv = rv; r.ra = ra;
        r.fl = fl; r.ov = ov; r.dr = dr;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: the FIFO as a plain queue; pop happens first so a full FIFO accepts push+pop.
    task automatic model_step(input bit v, input logic [ADDR_W-1:0] a, input bit c, input bit p);
        if (c) begin
            model_q.delete();
            model_ovf   = 1'b0;
            model_drops = 0;
        end else begin
            if (p && model_q.size() > 0) void'(model_q.pop_front());
            if (v) begin
                if (model_q.size() < int'(DEPTH)) begin
                    model_q.push_back({a, mkdata(a)});
                end else begin
                    model_ovf = 1'b1;
                    if (model_drops < 65535) model_drops++;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [ADDR_W-1:0] a, input bit c, input bit p);
        logic [ADDR_W-1:0] junk;
        junk          = ADDR_W'($urandom);
        bus.cap_valid = v;
        bus.cap_addr  = v ? a : junk;
        bus.cap_data  = v ? mkdata(a) : {junk, junk, junk};
        bus.clr       = c;
        bus.pop       = p;
        model_step(v, a, c, p);
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.cap_valid = 1'b0;
        bus.cap_addr  = '0;
        bus.cap_data  = '0;
        bus.clr       = 1'b0;
        bus.pop       = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
        rst = 1'b0;
        model_q.delete();
        model_ovf   = 1'b0;
        model_drops = 0;
    endtask

    task automatic compare_all(input string name);
        entry_t e;
        check({name, ".count"}, 64'(bus.count), 64'(model_q.size()));
        check({name, ".rd_valid"}, 64'(bus.rd_valid), 64'(model_q.size() != 0));
        check({name, ".full"}, 64'(bus.full), 64'(model_q.size() == int'(DEPTH)));
        check({name, ".overflow"}, 64'(bus.overflow), 64'(model_ovf));
        check({name, ".drop_cnt"}, 64'(bus.drop_cnt), DROP_EN ? 64'(model_drops) : 64'(0));
        if (model_q.size() > 0) begin
            e = model_q[0];
            check({name, ".rd_addr"}, 64'(bus.rd_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
            check({name, ".rd_data"}, 64'(bus.rd_data), 64'(e[DATA_W-1:0]));
        end
    endtask

    initial begin
        // Directed table: in-order drain, empty corners, fill, full push+pop, drops, clr.
        vecs.push_back(mk(1, 16'h0010, 0, 0, 1, 1, 16'h0010, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0011, 0, 0, 2, 1, 16'h0010, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0012, 0, 0, 3, 1, 16'h0010, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 2, 1, 16'h0011, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 1, 16'h0012, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0020, 0, 1, 1, 1, 16'h0020, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 16'h0030 + 16'(i), 0, 0, i + 1, 1, 16'h0030, i == 7, 0, 0));
        vecs.push_back(mk(1, 16'h0040, 0, 1, 8, 1, 16'h0031, 1, 0, 0));
        vecs.push_back(mk(1, 16'h0041, 0, 0, 8, 1, 16'h0031, 1, 1, 1));
        vecs.push_back(mk(1, 16'h0042, 0, 0, 8, 1, 16'h0031, 1, 1, 2));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 16'h0000, 0, 1, 7 - i, 1,
                              (i < 6) ? 16'h0032 + 16'(i) : 16'h0040, 0, 1, 2));
        vecs.push_back(mk(1, 16'h0050, 1, 1, 0, 0, 16'h0000, 0, 0, 0));

        do_reset();
        check("reset.count", 64'(bus.count), 64'(0));
        check("reset.rd_valid", 64'(bus.rd_valid), 64'(0));
        check("reset.full", 64'(bus.full), 64'(0));
        check("reset.overflow", 64'(bus.overflow), 64'(0));
        check("reset.drop_cnt", 64'(bus.drop_cnt), 64'(0));

        foreach (vecs[i]) begin
            string n;
            n = $sformatf("vec%0d", i);
            cycle(vecs[i].v, vecs[i].a, vecs[i].c, vecs[i].p);
            check({n, ".count"}, 64'(bus.count), 64'(vecs[i].cnt));
            check({n, ".rd_valid"}, 64'(bus.rd_valid), 64'(vecs[i].rv));
            check({n, ".full"}, 64'(bus.full), 64'(vecs[i].fl));
            check({n, ".overflow"}, 64'(bus.overflow), 64'(vecs[i].ov));
            check({n, ".drop_cnt"}, 64'(bus.drop_cnt), DROP_EN ? 64'(vecs[i].dr) : 64'(0));
            if (vecs[i].rv) begin
                check({n, ".rd_addr"}, 64'(bus.rd_addr), 64'(vecs[i].ra));
                check({n, ".rd_data"}, 64'(bus.rd_data), 64'(mkdata(vecs[i].ra)));
            end
        end

        // Three entries with overflow set, then clr racing a capture.
        for (int i = 0; i < 9; i++) cycle(1, 16'h0100 + 16'(i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 16'h0, 0, 1);
        compare_all("pre_clr");
        cycle(1, 16'h01AA, 1, 0);
        check("clr.count", 64'(bus.count), 64'(0));
        check("clr.rd_valid", 64'(bus.rd_valid), 64'(0));
        check("clr.overflow", 64'(bus.overflow), 64'(0));
        check("clr.drop_cnt", 64'(bus.drop_cnt), 64'(0));

        // Push/pop pairs crossing the pointer wrap several times.
        for (int i = 0; i < 20; i++) begin
            cycle(1, 16'h0200 + 16'(i), 0, 0);
            compare_all($sformatf("wrap%0d.push", i));
            check($sformatf("wrap%0d.rd_addr_abs", i), 64'(bus.rd_addr), 64'(16'h0200 + 16'(i)));
            check($sformatf("wrap%0d.count_le1", i), 64'(bus.count <= 1), 64'(1));
            cycle(0, 16'h0, 0, 1);
            compare_all($sformatf("wrap%0d.pop", i));
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 60, ADDR_W'($urandom), $urandom_range(0, 49) == 0,
                  $urandom_range(0, 99) < 45);
            compare_all($sformatf("rand%0d", i));
        end

        // Reset with entries pending clears status.
        for (int i = 0; i < 4; i++) cycle(1, 16'h0300 + 16'(i), 0, 0);
        do_reset();
        compare_all("final_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
